bin_ascii_streamer: RTL
=======================

# bin_ascii_streamer

Parametrised, handshaked binary-to-ASCII formatter for the debug/display path of the pipelined processor. It accepts one WIDTH-bit word per transaction and streams its printable text representation one byte per cycle: binary, uppercase hex, unsigned decimal or signed decimal, optionally newline-terminated. It sits between pipeline debug taps (register/PC/ALU values) and the character sink (UART TX FIFO or display driver). Decimal conversion is done sequentially inside the block.

## Interface
- WIDTH, 32, data word width; legal range 1..64.
- APPEND_NL, 1, when 1 a 0x0A byte follows the last digit of every word.

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data/in_mode valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  word to format.
- in_mode  input  2  00 binary, 01 hex, 10 unsigned decimal, 11 signed decimal.
- out_valid  output  1  out_char valid.
- out_ready  input  1  sink accepts out_char.
- out_char  output  8  ASCII byte.
- out_last  output  1  marks final byte of the word.
- busy  output  1  high in any state but IDLE.

## Operation
- States: IDLE, CONVERT, EMIT.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_data and in_mode. Go to EMIT for modes 00/01, CONVERT for 10/11.
- Binary: WIDTH chars, MSB first, 0x30/0x31.
- Hex: NHEX=ceil(WIDTH/4) chars, most significant nibble first, upper nibble zero-extended. Digits 0x30-0x39 and 0x41-0x46 ('A'-'F'). Leading zeros are kept.
- Unsigned decimal: magnitude = in_data.
- Signed decimal: if in_data[WIDTH-1]=1, magnitude = two's-complement negation taken as a WIDTH-bit unsigned value, so -2^(WIDTH-1) is represented correctly, and '-' (0x2D) is emitted first. Otherwise it is treated as unsigned.
- CONVERT: shift-add-3 (double-dabble), one magnitude bit per cycle, exactly WIDTH cycles.
  - Result is NDEC BCD digits, where NDEC is the digit count of 2^WIDTH-1 (constant function: WIDTH=1→1, 8→3, 32→10, 64→20).
  - Then go to EMIT.
- Decimal leading zeros are suppressed. Value 0 emits the single char '0'.
- EMIT: present one byte at a time. Advance on out_valid&&out_ready.
  - The final byte is the last digit, or 0x0A when APPEND_NL=1. out_last=1 only with the final byte.
  - After the final byte transfers, go to IDLE.
- in_valid while busy is ignored and no word is captured. The source must hold it until in_ready.

## Timing
- Reset state (rst_n low at a rising edge):
  - state IDLE; out_valid=0, out_char=0x00, out_last=0, busy=0.
  - in_ready=0 during reset, rising to 1 on the first rising edge with rst_n high.
  - Internal shift/BCD registers are cleared.
- All outputs are registered.
- Accept-to-first-byte latency, for an accept at edge N:
  - Modes 00/01: out_valid=1 after edge N+1.
  - Modes 10/11: out_valid=1 after edge N+1+WIDTH.
- Throughput: one byte per cycle while out_ready=1. No bubbles inside a word.
- Backpressure: while out_valid=1 and out_ready=0, out_char and out_last hold stable. out_valid never drops before its transfer.
- End of word: the edge that transfers the out_last byte clears out_valid and busy and sets in_ready. The next word can be accepted on the following edge, giving one idle cycle between words.
- Byte counts per word (each +1 when APPEND_NL=1):
  - binary: WIDTH
  - hex: NHEX
  - decimal: significant digits, +1 for '-'
- Reset mid-CONVERT or mid-EMIT: the stream is aborted at that edge. No out_last is issued and no partial state survives. Behaviour is then as after any reset.
- Simultaneous events:
  - in_valid on the edge that transfers out_last is not captured, because in_ready was 0.
  - A reset edge overrides any handshake occurring on that edge.

## Test plan
- WIDTH=8, APPEND_NL=1, mode 00, in_data=0xA5, out_ready=1 → "10100101\n" on 9 consecutive cycles, out_last only on 0x0A, first byte 1 cycle after accept.
- WIDTH=32, mode 01, in_data=0xDEADBEEF, then 0x0000000F → "DEADBEEF\n", then "0000000F\n". in_ready is high exactly 1 cycle after each out_last transfer.
- WIDTH=32, mode 10, in_data=0 → "0\n"; in_data=0xFFFFFFFF → "4294967295\n", with first out_valid 33 cycles after accept.
- WIDTH=32, mode 11: 0x80000000 → "-2147483648\n"; 0xFFFFFFFF → "-1\n"; 0x0000007B → "123\n". WIDTH=1, mode 11, in_data=1 → "-1\n".
- Backpressure: WIDTH=16, mode 10, in_data=0xFFFF, out_ready pseudo-random, in_valid held high throughout → exactly "65535\n". Bytes are stable while stalled, and no second capture occurs before in_ready.
- Reset mid-stream: assert rst_n=0 after the 3rd byte of "4294967295" → outputs are at reset values after that edge, in_ready=0 during reset and 1 one cycle after release. A following 0x0000002A in mode 10 yields "42\n" cleanly.

Source files
------------

// File: rtl/bin_ascii_streamer.sv
// Handshaked binary/hex/decimal ASCII formatter streaming one byte per cycle.
// Decimal values are converted in-block by a bit-serial double-dabble.
module bin_ascii_streamer #(
    parameter int WIDTH     = 32,
    parameter bit APPEND_NL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_last,
    output logic             busy
);

    function automatic int calc_ndec(input int w);
        logic [63:0] v;
        int          n;
        v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                v = v / 64'd10;
                n = n + 1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : ({4'h0, n} + 8'h37);
    endfunction

    localparam int NHEX = (WIDTH + 3) / 4;
    localparam int HEXW = 4 * NHEX;
    localparam int NDEC = calc_ndec(WIDTH);
    localparam int BCDW = 4 * NDEC;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_data;
    logic [1:0]        r_mode;
    logic              r_neg;
    logic [WIDTH-1:0]  r_shift;
    logic [BCDW-1:0]   r_bcd;
    logic [7:0]        r_cnt;
    logic [7:0]        r_pos;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [7:0]        r_out_char;
    logic              r_out_last;
    logic              r_busy;

    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_xfer;
    logic              w_neg_in;
    logic [BCDW-1:0]   w_bcd_adj;
    logic [7:0]        w_ndig;
    logic [7:0]        w_body_len;
    logic [7:0]        w_last_pos;
    logic [7:0]        w_pos;
    logic [7:0]        w_dig_k;
    logic [HEXW-1:0]   w_hex_src;
    logic              w_bit;
    logic [3:0]        w_nib;
    logic [3:0]        w_dig;
    logic [7:0]        w_char;
    logic              w_is_last;

    assign w_accept  = in_valid && r_in_ready;
    assign w_xfer    = r_out_valid && out_ready;
    assign w_neg_in  = (in_mode == 2'b11) && in_data[WIDTH-1];
    assign w_hex_src = HEXW'(r_data);

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_char  = r_out_char;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

    // Double-dabble correction: add 3 to every BCD digit of 5 or more before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NDEC; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end else begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4];
            end
        end
    end

    // Significant decimal digit count; a zero value still prints one digit.
    always_comb begin
        w_ndig = 8'd1;
        for (int i = 1; i < NDEC; i++) begin
            w_ndig = (r_bcd[4*i +: 4] != 4'd0) ? 8'(i + 1) : w_ndig;
        end
    end

    // Character at the position about to be presented (0 on first load, else next).
    always_comb begin
        w_pos = r_out_valid ? (r_pos + 8'd1) : 8'd0;
        case (r_mode)
            2'b00:   w_body_len = 8'(WIDTH);
            2'b01:   w_body_len = 8'(NHEX);
            default: w_body_len = w_ndig + {7'd0, r_neg};
        endcase
        w_last_pos = APPEND_NL ? w_body_len : (w_body_len - 8'd1);
        w_dig_k    = w_ndig - 8'd1 + {7'd0, r_neg} - w_pos;
        w_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_bit = (8'(WIDTH - 1 - i) == w_pos) ? r_data[i] : w_bit;
        end
        w_nib = 4'd0;
        for (int i = 0; i < NHEX; i++) begin
            w_nib = (8'(NHEX - 1 - i) == w_pos) ? w_hex_src[4*i +: 4] : w_nib;
        end
        w_dig = 4'd0;
        for (int i = 0; i < NDEC; i++) begin
            w_dig = (8'(i) == w_dig_k) ? r_bcd[4*i +: 4] : w_dig;
        end
        if (APPEND_NL && (w_pos == w_body_len)) begin
            w_char = 8'h0A;
        end else begin
            case (r_mode)
                2'b00:   w_char = w_bit ? 8'h31 : 8'h30;
                2'b01:   w_char = hex_ascii(w_nib);
                default: w_char = (r_neg && (w_pos == 8'd0)) ? 8'h2D : {4'h3, w_dig};
            endcase
        end
        w_is_last = (w_pos == w_last_pos);
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = in_mode[1] ? S_CONVERT : S_EMIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CONVERT: begin
                if (r_cnt == 8'(WIDTH - 1)) begin
                    w_state_nxt = S_EMIT;
                end else begin
                    w_state_nxt = S_CONVERT;
                end
            end
            S_EMIT: begin
                if (w_xfer && r_out_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_EMIT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data      <= {WIDTH{1'b0}};
            r_mode      <= 2'b00;
            r_neg       <= 1'b0;
            r_shift     <= {WIDTH{1'b0}};
            r_bcd       <= {BCDW{1'b0}};
            r_cnt       <= 8'd0;
            r_pos       <= 8'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_char  <= 8'h00;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == S_IDLE);
            r_busy     <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_data  <= in_data;
                        r_mode  <= in_mode;
                        r_neg   <= w_neg_in;
                        r_shift <= w_neg_in ? (~in_data + WIDTH'(1)) : in_data;
                        r_bcd   <= {BCDW{1'b0}};
                        r_cnt   <= 8'd0;
                    end
                end
                S_CONVERT: begin
                    r_bcd   <= BCDW'({w_bcd_adj, r_shift[WIDTH-1]});
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + 8'd1;
                end
                S_EMIT: begin
                    if (!r_out_valid || (out_ready && !r_out_last)) begin
                        r_pos       <= w_pos;
                        r_out_char  <= w_char;
                        r_out_last  <= w_is_last;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_char  <= 8'h00;
                        r_out_last  <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
